// File: rtl/pool_channel_scheduler.sv
// rtl/pool_channel_scheduler.sv - per-channel sequencer and address relocator for the 2x2 max-pool engine
// Optional per-channel watchdog is compiled in when POOL_WDOG_EN is defined.
module pool_channel_scheduler #(
  parameter int IN_MAP_SIZE  = 676,
  parameter int OUT_MAP_SIZE = 169,
  parameter int MAX_CH       = 16,
  parameter int CH_W         = 5,
  parameter int IN_ADDR_W    = 14,
  parameter int OUT_ADDR_W   = 12
`ifdef POOL_WDOG_EN
  ,
  parameter int TIMEOUT      = 2048
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CH_W-1:0]       num_channels,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CH_W-1:0]       cur_channel,
  output logic                  eng_start,
  input  logic                  eng_done,
  input  logic [9:0]            eng_rd_addr,
  input  logic [7:0]            eng_wr_addr,
  input  logic                  eng_wr_en,
  output logic [IN_ADDR_W-1:0]  mem_rd_addr,
  output logic [OUT_ADDR_W-1:0] mem_wr_addr,
  output logic                  mem_wr_en
);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FINISH} state_e;

  localparam logic [CH_W-1:0]       MAX_CH_V = CH_W'(MAX_CH);
  localparam logic [IN_ADDR_W-1:0]  IN_STEP  = IN_ADDR_W'(IN_MAP_SIZE);
  localparam logic [OUT_ADDR_W-1:0] OUT_STEP = OUT_ADDR_W'(OUT_MAP_SIZE);

  state_e                state_q;
  logic                  busy_q, done_q, eng_start_q, eng_done_q;
  logic [CH_W-1:0]       cur_channel_q, n_q;
  logic [IN_ADDR_W-1:0]  in_base_q;
  logic [OUT_ADDR_W-1:0] out_base_q;
  logic                  done_edge, last_ch;
  logic [CH_W-1:0]       n_d;

  // A done level left high by the previous channel must not count as completion.
  assign done_edge = eng_done & ~eng_done_q;
  assign last_ch   = (cur_channel_q == n_q - 1'b1);
  assign n_d       = (num_channels > MAX_CH_V) ? MAX_CH_V : num_channels;

`ifdef POOL_WDOG_EN
  localparam int                WDOG_W    = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  logic [WDOG_W-1:0] wdog_q;
  logic              err_q;
  logic              wdog_fire;
  assign wdog_fire = (wdog_q == WDOG_LAST);
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      eng_start_q   <= 1'b0;
      eng_done_q    <= 1'b0;
      cur_channel_q <= '0;
      n_q           <= '0;
      in_base_q     <= '0;
      out_base_q    <= '0;
`ifdef POOL_WDOG_EN
      wdog_q        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      eng_done_q  <= eng_done;
      eng_start_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
`ifdef POOL_WDOG_EN
              err_q <= 1'b0;
`endif
              if (num_channels == '0) begin
                done_q <= 1'b1;
              end else begin
                done_q        <= 1'b0;
                busy_q        <= 1'b1;
                n_q           <= n_d;
                cur_channel_q <= '0;
                in_base_q     <= '0;
                out_base_q    <= '0;
                eng_start_q   <= 1'b1;
                state_q       <= S_LAUNCH;
              end
            end
          end
          S_LAUNCH: begin
`ifdef POOL_WDOG_EN
            wdog_q <= '0;
`endif
            state_q <= S_RUN;
          end
          S_RUN: begin
            if (done_edge) begin
              if (last_ch) begin
                state_q <= S_FINISH;
              end else begin
                cur_channel_q <= cur_channel_q + 1'b1;
                in_base_q     <= in_base_q + IN_STEP;
                out_base_q    <= out_base_q + OUT_STEP;
                eng_start_q   <= 1'b1;
                state_q       <= S_LAUNCH;
              end
            end
`ifdef POOL_WDOG_EN
            else if (wdog_fire) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              wdog_q <= wdog_q + 1'b1;
            end
`endif
          end
          S_FINISH: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cur_channel = cur_channel_q;
  assign eng_start   = eng_start_q & ~abort;
  assign mem_rd_addr = in_base_q + IN_ADDR_W'(eng_rd_addr);
  assign mem_wr_addr = out_base_q + OUT_ADDR_W'(eng_wr_addr);
  // After an abort the engine may still be writing; keep those writes out of memory.
  assign mem_wr_en   = eng_wr_en & busy_q;

  addr_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    (int'(in_base_q) + int'(eng_rd_addr) < (1 << IN_ADDR_W)) &&
    (int'(out_base_q) + int'(eng_wr_addr) < (1 << OUT_ADDR_W)));
endmodule

// File: tb/tb_pool_channel_scheduler.sv
// tb/tb_pool_channel_scheduler.sv - directed bench for pool_channel_scheduler with a behavioural engine
module tb_pool_channel_scheduler;
  localparam int CH_W = 5, IN_ADDR_W = 14, OUT_ADDR_W = 12, ENG_T = 847;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [CH_W-1:0] num_channels = '0;
  logic busy, done, err, eng_start, mem_wr_en, eng_done, eng_wr_en;
  logic [CH_W-1:0] cur_channel;
  logic [9:0] eng_rd_addr;
  logic [7:0] eng_wr_addr;
  logic [IN_ADDR_W-1:0] mem_rd_addr;
  logic [OUT_ADDR_W-1:0] mem_wr_addr;

  bit eng_auto = 1'b0;
  logic man_done = 1'b0, man_wr_en = 1'b0;
  logic [9:0] man_rd = '0;
  logic [7:0] man_wr = '0;
  int mdl_cnt = ENG_T;
  bit mdl_act = 1'b0;
  logic mdl_done = 1'b0;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pool_channel_scheduler dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .num_channels(num_channels),
    .busy(busy), .done(done), .err(err), .cur_channel(cur_channel), .eng_start(eng_start),
    .eng_done(eng_done), .eng_rd_addr(eng_rd_addr), .eng_wr_addr(eng_wr_addr), .eng_wr_en(eng_wr_en),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_en(mem_wr_en)
  );

  // Engine: reads 0..675, writes 0..168 well before done, done level after ENG_T cycles.
  always @(posedge clk) begin
    if (eng_start) begin
      mdl_cnt  <= 0;
      mdl_act  <= 1'b1;
      mdl_done <= 1'b0;
    end else if (mdl_act) begin
      if (mdl_cnt == ENG_T - 1) begin
        mdl_act  <= 1'b0;
        mdl_done <= 1'b1;
      end
      mdl_cnt <= mdl_cnt + 1;
    end
  end

  assign eng_done    = eng_auto ? mdl_done : man_done;
  assign eng_rd_addr = eng_auto ? ((mdl_cnt < 676) ? 10'(mdl_cnt) : 10'd0) : man_rd;
  assign eng_wr_en   = eng_auto ? (mdl_act && mdl_cnt >= 100 && mdl_cnt < 269) : man_wr_en;
  assign eng_wr_addr = eng_auto ? 8'(mdl_cnt - 100) : man_wr;

  int mon_pulses, mon_maxw, mon_run, mon_wr_max, mon_wr_min, mon_rd_max;
  bit mon_clr = 1'b0;
  always @(negedge clk) begin
    if (mon_clr) begin
      mon_pulses = 0; mon_maxw = 0; mon_run = 0;
      mon_wr_max = -1; mon_wr_min = 1 << 30; mon_rd_max = -1;
    end else begin
      if (eng_start) begin
        if (mon_run == 0) mon_pulses++;
        mon_run++;
        if (mon_run > mon_maxw) mon_maxw = mon_run;
      end else begin
        mon_run = 0;
      end
      if (mem_wr_en) begin
        if (int'(mem_wr_addr) > mon_wr_max) mon_wr_max = int'(mem_wr_addr);
        if (int'(mem_wr_addr) < mon_wr_min) mon_wr_min = int'(mem_wr_addr);
      end
      if (busy && int'(mem_rd_addr) > mon_rd_max) mon_rd_max = int'(mem_rd_addr);
    end
  end

`ifdef POOL_WDOG_EN
  logic wd_start = 1'b0, wd_abort = 1'b0, wd_zero = 1'b0;
  logic [CH_W-1:0] wd_n = '0;
  logic wd_busy, wd_done, wd_err, wd_eng_start, wd_wr_en;
  logic [CH_W-1:0] wd_cur;
  logic [IN_ADDR_W-1:0] wd_rd;
  logic [OUT_ADDR_W-1:0] wd_wr;
  pool_channel_scheduler #(.TIMEOUT(64)) dut_wd (
    .clk(clk), .reset_n(reset_n), .start(wd_start), .abort(wd_abort), .num_channels(wd_n),
    .busy(wd_busy), .done(wd_done), .err(wd_err), .cur_channel(wd_cur), .eng_start(wd_eng_start),
    .eng_done(wd_zero), .eng_rd_addr(man_rd), .eng_wr_addr(man_wr), .eng_wr_en(man_wr_en),
    .mem_rd_addr(wd_rd), .mem_wr_addr(wd_wr), .mem_wr_en(wd_wr_en)
  );
`endif

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_reset();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  typedef struct {
    int n;
    int pulses;
    int wr_max;
    int rd_max;
    int cur;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int k;
    tbl[0] = '{3, 3, 506, 2027, 2};
    tbl[1] = '{1, 1, 168, 675, 0};
    tbl[2] = '{2, 2, 337, 1351, 1};
    tbl[3] = '{0, 0, -1, -1, 1};
    tbl[4] = '{20, 16, 2703, 10815, 15};
    tbl[5] = '{16, 16, 2703, 10815, 15};

    man_rd = 10'd5; man_wr = 8'd7; man_wr_en = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur", cur_channel, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_rd_addr", mem_rd_addr, 5);
    chk("rst_wr_addr", mem_wr_addr, 7);
    chk("rst_wr_en_masked", mem_wr_en, 0);
    man_wr_en = 1'b0;
    reset_n = 1'b1;
    tick();

    mon_reset();
    num_channels = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_no_start", mon_pulses, 0);

    eng_auto = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mon_reset();
      num_channels = CH_W'(tbl[i].n); start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (!(done && !busy) && k < tbl[i].pulses * 900 + 20) begin
        tick();
        k++;
      end
      chk($sformatf("tbl%0d_finished", i), int'(done && !busy), 1);
      tick();
      chk($sformatf("tbl%0d_pulses", i), mon_pulses, tbl[i].pulses);
      chk($sformatf("tbl%0d_pulse_width", i), mon_maxw, (tbl[i].pulses > 0) ? 1 : 0);
      chk($sformatf("tbl%0d_wr_max", i), mon_wr_max, tbl[i].wr_max);
      chk($sformatf("tbl%0d_rd_max", i), mon_rd_max, tbl[i].rd_max);
      chk($sformatf("tbl%0d_cur", i), cur_channel, tbl[i].cur);
      chk($sformatf("tbl%0d_done_hold", i), done, 1);
      chk($sformatf("tbl%0d_err", i), err, 0);
      if (tbl[i].pulses > 0) chk($sformatf("tbl%0d_wr_min", i), mon_wr_min, 0);
    end
    eng_auto = 1'b0;

    // Stale done level at start must not complete channel 0.
    man_done = 1'b1;
    tick(); tick();
    num_channels = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("stale_launch_pulse", eng_start, 1);
    chk("stale_busy", busy, 1);
    chk("stale_done_cleared", done, 0);
    tick();
    chk("stale_pulse_one_cycle", eng_start, 0);
    repeat (10) tick();
    chk("stale_still_busy", busy, 1);
    chk("stale_not_done", done, 0);
    man_done = 1'b0;
    tick(); tick();
    man_done = 1'b1;
    tick();
    chk("edge_finish_done", done, 0);
    tick();
    chk("edge_done_rise", done, 1);
    chk("edge_busy_fall", busy, 0);
    tick();
    chk("edge_done_hold", done, 1);

    // Abort in channel 1 of a 4-channel layer; start while busy is ignored.
    man_done = 1'b0;
    tick();
    num_channels = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    man_done = 1'b1;
    tick();
    chk("ch1_launch", eng_start, 1);
    chk("ch1_cur", cur_channel, 1);
    man_done = 1'b0;
    tick();
    man_wr = 8'd10; man_rd = 10'd20; man_wr_en = 1'b1;
    #1;
    chk("ch1_wr_reloc", mem_wr_addr, 179);
    chk("ch1_rd_reloc", mem_rd_addr, 696);
    chk("ch1_wr_en", mem_wr_en, 1);
    num_channels = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_cur", cur_channel, 1);
    chk("busy_start_busy", busy, 1);
    chk("busy_start_no_pulse", eng_start, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wr_masked", mem_wr_en, 0);
    num_channels = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_cur", cur_channel, 0);
    chk("restart_wr_base", mem_wr_addr, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    man_wr_en = 1'b0;

    // Asynchronous reset mid-run, away from any clock edge.
    num_channels = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    chk("pre_rst_cur", cur_channel, 1);
    chk("pre_rst_rd", mem_rd_addr, 696);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cur", cur_channel, 0);
    chk("arst_done", done, 0);
    chk("arst_rd_base", mem_rd_addr, 20);
    tick();
    reset_n = 1'b1;
    tick();

`ifdef POOL_WDOG_EN
    wd_n = 5'd1; wd_start = 1'b1;
    tick();
    wd_start = 1'b0;
    k = 0;
    while (!wd_done && k < 100) begin
      tick();
      k++;
    end
    chk("wdog_cycles", k, 65);
    chk("wdog_err", wd_err, 1);
    chk("wdog_busy", wd_busy, 0);
    chk("wdog_cur", wd_cur, 0);
    chk("wdog_eng_start", wd_eng_start, 0);
    chk("wdog_wr_en", wd_wr_en, 0);
    chk("wdog_rd", wd_rd, 20);
    chk("wdog_wr", wd_wr, 10);
    wd_start = 1'b1;
    tick();
    wd_start = 1'b0;
    chk("wdog_err_cleared", wd_err, 0);
    wd_abort = 1'b1;
    tick();
    wd_abort = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
